sample_skew_feeder: RTL and testbench

- Transmit-side front end of the systolic array: accepts complete training samples (input vector x plus desired response y) over a valid/ready handshake.
- Buffers samples in a small FIFO and injects them into the top VLINK of each array column with diagonal skew: column k is delayed k cycles, and y feeds the reference column last.
- Honours the global freeze and supports an explicit flush that drains in-flight skew data.
- Fixed-point data: signed DW bits.

---
 rtl/sysarr_pkg.sv | 20 ++
 rtl/skew_delay_line.sv | 55 +++++
 rtl/sample_skew_feeder.sv | 148 ++++++++++++++
 tb/tb_sample_skew_feeder.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sysarr_pkg.sv
// Shared types and defaults for the systolic-array sample feeder.
// The sample struct and state enum are used by the feeder and by code that talks to it.
package sysarr_pkg;

   localparam int DW_DEFAULT    = 16;
   localparam int N_DIM_DEFAULT = 3;

   // One training sample: the input vector plus its desired response
   typedef struct packed {
      logic signed [N_DIM_DEFAULT-1:0][DW_DEFAULT-1:0] x;
      logic signed [DW_DEFAULT-1:0]                    y;
   } sample_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } feeder_state_e;

endpackage

// File: rtl/skew_delay_line.sv
// LEN-deep data+valid register chain; LEN=0 is a plain wire.
// Data only advances with a valid beat, so lines hold their last value across bubbles.
module skew_delay_line #(
   parameter int DW  = 16,
   parameter int LEN = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          hold,
   input  logic [DW-1:0] in_data,
   input  logic          in_valid,
   output logic [DW-1:0] out_data,
   output logic          out_valid
);

   generate
      if (LEN == 0) begin : g_wire
         logic unused_ctl;
         assign unused_ctl = ^{clk, rst, hold};
         assign out_data   = in_data;
         assign out_valid  = in_valid;
      end else begin : g_regs
         logic [DW-1:0]  d     [LEN];
         logic [LEN-1:0] v;
         logic [DW-1:0]  src_d [LEN];
         logic [LEN-1:0] src_v;

         for (genvar i = 0; i < LEN; i++) begin : g_src
            if (i == 0) begin : g_head
               assign src_d[i] = in_data;
               assign src_v[i] = in_valid;
            end else begin : g_tail
               assign src_d[i] = d[i-1];
               assign src_v[i] = v[i-1];
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               v <= '0;
               for (int i = 0; i < LEN; i++) d[i] <= '0;
            end else if (!hold) begin
               for (int i = 0; i < LEN; i++) begin
                  v[i] <= src_v[i];
                  if (src_v[i]) d[i] <= src_d[i];
               end
            end
         end

         assign out_data  = d[LEN-1];
         assign out_valid = v[LEN-1];
      end
   endgenerate

endmodule

// File: rtl/sample_skew_feeder.sv
// Buffers training samples and injects them diagonally skewed into the array columns.
// Handshake: a sample moves when s_valid && s_ready in the same cycle; s_ready is simply !fifo_full.
module sample_skew_feeder
   import sysarr_pkg::*;
#(
   parameter int N_DIM = N_DIM_DEFAULT,
   parameter int DW    = DW_DEFAULT,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       freeze,
   input  logic                       flush,
   input  logic                       s_valid,
   output logic                       s_ready,
   input  logic [N_DIM*DW-1:0]        s_x,
   input  logic [DW-1:0]              s_y,
   output logic [N_DIM*DW-1:0]        col_x,
   output logic [N_DIM-1:0]           col_valid,
   output logic [DW-1:0]              ref_y,
   output logic                       ref_valid,
   output logic                       busy,
   output logic [$clog2(N_DIM+2)-1:0] inflight
);

   localparam int             AW       = $clog2(DEPTH);
   localparam int             IW       = $clog2(N_DIM+2);
   localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

   feeder_state_e state, state_nxt;

   logic [N_DIM*DW-1:0] fifo_x [DEPTH];
   logic [DW-1:0]       fifo_y [DEPTH];
   logic [AW-1:0]       wr_ptr, rd_ptr;
   logic [AW:0]         count;
   logic                fifo_full, fifo_empty;
   logic                push, pop, emit;

   logic                s0_valid;
   logic [N_DIM*DW-1:0] s0_x;
   logic [DW-1:0]       s0_y;

   assign fifo_full  = (count == FULL_CNT);
   assign fifo_empty = (count == '0);
   assign s_ready    = !fifo_full;
   assign push       = s_valid && s_ready;
   assign pop        = (state == RUN) && !freeze && !fifo_empty;
   assign busy       = (state != IDLE);

   // The last x column leads the reference column by exactly one stage,
   // so its valid tells us a y will land on ref_valid at the next live edge.
   assign emit = !freeze && col_valid[N_DIM-1];

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_x[wr_ptr] <= s_x;
         fifo_y[wr_ptr] <= s_y;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         unique case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:  if (push) state_nxt = RUN;
         RUN: begin
            if (flush)
               state_nxt = FLUSH;
            else if (fifo_empty && (inflight == '0) && !push)
               state_nxt = IDLE;
         end
         FLUSH: begin
            if (inflight == '0)
               state_nxt = (!fifo_empty || push) ? RUN : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         inflight <= '0;
      end else begin
         state <= state_nxt;
         unique case ({pop, emit})
            2'b10:   inflight <= inflight + IW'(1);
            2'b01:   inflight <= inflight - IW'(1);
            default: inflight <= inflight;
         endcase
      end
   end

   // Launch stage: every column and the reference sit behind this register
   always_ff @(posedge clk) begin
      if (rst) begin
         s0_valid <= 1'b0;
         s0_x     <= '0;
         s0_y     <= '0;
      end else if (!freeze) begin
         s0_valid <= pop;
         if (pop) begin
            s0_x <= fifo_x[rd_ptr];
            s0_y <= fifo_y[rd_ptr];
         end
      end
   end

   generate
      for (genvar k = 0; k < N_DIM; k++) begin : g_col
         skew_delay_line #(.DW(DW), .LEN(k)) u_col (
            .clk       (clk),
            .rst       (rst),
            .hold      (freeze),
            .in_data   (s0_x[k*DW +: DW]),
            .in_valid  (s0_valid),
            .out_data  (col_x[k*DW +: DW]),
            .out_valid (col_valid[k])
         );
      end
   endgenerate

   skew_delay_line #(.DW(DW), .LEN(N_DIM)) u_ref (
      .clk       (clk),
      .rst       (rst),
      .hold      (freeze),
      .in_data   (s0_y),
      .in_valid  (s0_valid),
      .out_data  (ref_y),
      .out_valid (ref_valid)
   );

endmodule

// File: tb/tb_sample_skew_feeder.sv
// Bench for sample_skew_feeder: launch-history model checked every cycle plus directed literals.
module tb_sample_skew_feeder;

   localparam int N_DIM = 3;
   localparam int DW    = 16;
   localparam int DEPTH = 4;
   localparam int IW    = $clog2(N_DIM+2);
   localparam int HN    = 2048;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                freeze = 1'b0;
   logic                flush = 1'b0;
   logic                s_valid = 1'b0;
   logic                s_ready;
   logic [N_DIM*DW-1:0] s_x = '0;
   logic [DW-1:0]       s_y = '0;
   logic [N_DIM*DW-1:0] col_x;
   logic [N_DIM-1:0]    col_valid;
   logic [DW-1:0]       ref_y;
   logic                ref_valid;
   logic                busy;
   logic [IW-1:0]       inflight;

   int checks = 0;
   int errors = 0;

   sample_skew_feeder #(.N_DIM(N_DIM), .DW(DW), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .freeze    (freeze),
      .flush     (flush),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_x       (s_x),
      .s_y       (s_y),
      .col_x     (col_x),
      .col_valid (col_valid),
      .ref_y     (ref_y),
      .ref_valid (ref_valid),
      .busy      (busy),
      .inflight  (inflight)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a FIFO queue, the launch decision per live edge, and a history of launches.
   // Outputs follow from "column k shows the launch made k live edges ago".
   typedef enum int {M_IDLE, M_RUN, M_FLUSH} m_state_t;
   m_state_t            m_state = M_IDLE;
   logic [N_DIM*DW-1:0] mq_x [$];
   logic [DW-1:0]       mq_y [$];
   int                  n = 0;
   bit                  hist_v [HN];
   logic [N_DIM*DW-1:0] hist_x [HN];
   logic [DW-1:0]       hist_y [HN];

   function automatic int m_inflight();
      int c = 0;
      for (int i = n - N_DIM + 1; i <= n; i++)
         if (i >= 1 && hist_v[i]) c++;
      return c;
   endfunction

   function automatic logic m_valid(input int lag);
      if (n - lag < 1) return 1'b0;
      return hist_v[n-lag];
   endfunction

   function automatic logic [DW-1:0] m_data(input int sel, input int lag);
      logic [N_DIM*DW-1:0] tx;
      for (int i = n - lag; i >= 1; i--) begin
         if (hist_v[i]) begin
            if (sel == N_DIM) return hist_y[i];
            tx = hist_x[i];
            return tx[sel*DW +: DW];
         end
      end
      return '0;
   endfunction

   initial begin
      bit                  m_push, m_pop, m_empty;
      int                  m_infl;
      logic [N_DIM*DW-1:0] px;
      logic [DW-1:0]       py;
      forever begin
         @(posedge clk);
         if (rst) begin
            mq_x.delete();
            mq_y.delete();
            m_state = M_IDLE;
            n = 0;
         end else begin
            px      = '0;
            py      = '0;
            m_empty = (mq_x.size() == 0);
            m_push  = s_valid && (mq_x.size() < DEPTH);
            m_pop   = (m_state == M_RUN) && !freeze && !m_empty;
            m_infl  = m_inflight();
            case (m_state)
               M_IDLE:  if (m_push) m_state = M_RUN;
               M_RUN: begin
                  if (flush) m_state = M_FLUSH;
                  else if (m_empty && m_infl == 0 && !m_push) m_state = M_IDLE;
               end
               default: begin
                  if (m_infl == 0) m_state = (!m_empty || m_push) ? M_RUN : M_IDLE;
               end
            endcase
            if (m_pop) begin
               px = mq_x.pop_front();
               py = mq_y.pop_front();
            end
            if (m_push) begin
               mq_x.push_back(s_x);
               mq_y.push_back(s_y);
            end
            if (!freeze && n < HN - 1) begin
               n++;
               hist_v[n] = m_pop;
               hist_x[n] = px;
               hist_y[n] = py;
            end
         end
      end
   end

   // Compare process: every output against the model, every cycle
   initial begin
      forever begin
         @(negedge clk);
         chk("s_ready", s_ready, mq_x.size() < DEPTH);
         chk("busy", busy, m_state != M_IDLE);
         chk("inflight", inflight, m_inflight());
         for (int k = 0; k < N_DIM; k++) begin
            chk($sformatf("col_valid%0d", k), col_valid[k], m_valid(k));
            chk($sformatf("col_x%0d", k), col_x[k*DW +: DW], m_data(k, k));
         end
         chk("ref_valid", ref_valid, m_valid(N_DIM));
         chk("ref_y", ref_y, m_data(N_DIM, N_DIM));
      end
   end

   int cnt_en = 0;
   int cnt_col0 = 0;
   int cnt_ref = 0;
   initial begin
      forever begin
         @(negedge clk);
         if (cnt_en != 0) begin
            if (col_valid[0]) cnt_col0++;
            if (ref_valid)    cnt_ref++;
         end
      end
   end

   // Called at a negedge; returns at the negedge after the accepting edge
   task automatic push(input logic [N_DIM*DW-1:0] x, input logic [DW-1:0] y);
      logic acc;
      int   guard;
      acc     = 1'b0;
      guard   = 0;
      s_valid = 1'b1;
      s_x     = x;
      s_y     = y;
      while (!acc && guard < 50) begin
         acc = s_ready;
         @(posedge clk);
         @(negedge clk);
         guard++;
      end
      s_valid = 1'b0;
      checks++;
      if (!acc) begin
         errors++;
         $display("FAIL push_timeout: got no accept expected accept within 50 cycles at %0t", $time);
      end
   endtask

   initial begin
      #100000;
      errors++;
      $display("FAIL watchdog: got still running expected finished at %0t", $time);
      $display("Result: errors=%0d of %0d checks", errors, checks + 1);
      $finish;
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_col_valid", col_valid, 3'b000);
      chk("rst_busy", busy, 1'b0);
      chk("rst_inflight", inflight, 3'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_s_ready", s_ready, 1'b1);

      // Flush while idle does nothing
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      @(negedge clk);
      chk("idle_flush_busy", busy, 1'b0);

      // Single sample x=(1,2,3), y=7
      push({16'd3, 16'd2, 16'd1}, 16'd7);
      @(negedge clk);
      chk("s1_cv_t1", col_valid, 3'b001);
      chk("s1_x0", col_x[15:0], 16'd1);
      chk("s1_infl_t1", inflight, 3'd1);
      @(negedge clk);
      chk("s1_cv_t2", col_valid, 3'b010);
      chk("s1_x1", col_x[31:16], 16'd2);
      @(negedge clk);
      chk("s1_cv_t3", col_valid, 3'b100);
      chk("s1_x2", col_x[47:32], 16'd3);
      chk("s1_infl_t3", inflight, 3'd1);
      @(negedge clk);
      chk("s1_rv_t4", ref_valid, 1'b1);
      chk("s1_ref", ref_y, 16'd7);
      chk("s1_infl_t4", inflight, 3'd0);
      chk("s1_cv_t4", col_valid, 3'b000);
      @(negedge clk);
      chk("s1_rv_t5", ref_valid, 1'b0);
      chk("s1_ref_hold", ref_y, 16'd7);
      chk("s1_x0_hold", col_x[15:0], 16'd1);
      chk("s1_busy_end", busy, 1'b0);
      repeat (3) @(negedge clk);

      // Freeze three cycles while a sample is half-way through the skew
      push({16'd30, 16'd20, 16'd10}, 16'd40);
      @(negedge clk);
      chk("fz_cv_t1", col_valid, 3'b001);
      freeze = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("fz_cv_hold", col_valid, 3'b001);
         chk("fz_x0_hold", col_x[15:0], 16'd10);
         chk("fz_infl_hold", inflight, 3'd1);
      end
      freeze = 1'b0;
      @(negedge clk);
      chk("fz_cv_t2", col_valid, 3'b010);
      chk("fz_x1", col_x[31:16], 16'd20);
      @(negedge clk);
      chk("fz_cv_t3", col_valid, 3'b100);
      chk("fz_x2", col_x[47:32], 16'd30);
      @(negedge clk);
      chk("fz_rv", ref_valid, 1'b1);
      chk("fz_ref", ref_y, 16'd40);
      chk("fz_infl_end", inflight, 3'd0);
      repeat (4) @(negedge clk);

      // Back-to-back: fill the FIFO under freeze, then stream 6 samples
      cnt_col0 = 0;
      cnt_ref  = 0;
      cnt_en   = 1;
      freeze   = 1'b1;
      for (int i = 1; i <= 4; i++)
         push({16'(100 + i), 16'(200 + i), 16'(300 + i)}, 16'(400 + i));
      chk("b2b_full_ready", s_ready, 1'b0);
      chk("b2b_busy", busy, 1'b1);
      freeze = 1'b0;
      for (int i = 5; i <= 6; i++)
         push({16'(100 + i), 16'(200 + i), 16'(300 + i)}, 16'(400 + i));
      repeat (12) @(negedge clk);
      cnt_en = 0;
      chk("b2b_col0_count", cnt_col0, 6);
      chk("b2b_ref_count", cnt_ref, 6);
      chk("b2b_last_ref", ref_y, 16'd406);
      repeat (3) @(negedge clk);

      // Flush with two samples in flight and one waiting in the FIFO
      push({16'd13, 16'd12, 16'd11}, 16'd14);
      push({16'd23, 16'd22, 16'd21}, 16'd24);
      chk("simul_ready", s_ready, 1'b1);
      flush = 1'b1;
      push({16'd33, 16'd32, 16'd31}, 16'd34);
      flush = 1'b0;
      @(negedge clk);
      chk("fl_nopop_e4", col_valid[0], 1'b0);
      @(negedge clk);
      chk("fl_nopop_e5", col_valid[0], 1'b0);
      chk("fl_ref_a", ref_y, 16'd14);
      @(negedge clk);
      chk("fl_nopop_e6", col_valid[0], 1'b0);
      chk("fl_ref_b", ref_y, 16'd24);
      chk("fl_infl_zero", inflight, 3'd0);
      @(negedge clk);
      chk("fl_nopop_e7", col_valid[0], 1'b0);
      chk("fl_busy", busy, 1'b1);
      @(negedge clk);
      chk("fl_c_launch", col_valid[0], 1'b1);
      chk("fl_c_x0", col_x[15:0], 16'd31);
      repeat (6) @(negedge clk);

      // Reset mid-stream: nothing survives
      push({16'd53, 16'd52, 16'd51}, 16'd54);
      push({16'd63, 16'd62, 16'd61}, 16'd64);
      rst = 1'b1;
      @(negedge clk);
      chk("mrst_col_valid", col_valid, 3'b000);
      chk("mrst_ref_valid", ref_valid, 1'b0);
      chk("mrst_inflight", inflight, 3'd0);
      chk("mrst_busy", busy, 1'b0);
      chk("mrst_col_x", col_x, '0);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("mrst_quiet_cv", col_valid, 3'b000);
         chk("mrst_quiet_rv", ref_valid, 1'b0);
      end
      chk("mrst_ready", s_ready, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
